// File: rtl/cpu8_multicycle_ctrl.sv
// Multi-cycle control unit for the 8-bit CPU: owns PC/IR, fetches over a
// req/ack handshake, decodes the 3-bit opcode and drives datapath strobes.
module cpu8_multicycle_ctrl #(
    parameter logic [7:0] PC_RESET    = 8'h00,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       zero_flag,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic [1:0] alu_op,
    output logic       alu_src_imm,
    output logic       reg_we,
    output logic       reg_wsel,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_BEQZ = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       fault_q, fault_d;
    logic [7:0] tcnt_q, tcnt_d;

    logic [2:0] op;
    logic [7:0] sext8;
    logic [7:0] pc_inc;
    logic [7:0] pc_rel;
    logic       timed_out;

    assign op        = ir_q[7:5];
    assign sext8     = {{5{ir_q[2]}}, ir_q[2:0]};
    assign pc_inc    = pc_q + 8'd1;
    assign pc_rel    = pc_q + sext8;
    // This wait cycle is the MEM_TIMEOUT-th one without an ack.
    assign timed_out = (tcnt_q >= TO_LAST);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        fault_d      = fault_q;
        tcnt_d       = tcnt_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_op       = 2'b00;
        alu_src_imm  = 1'b0;
        reg_we       = 1'b0;
        reg_wsel     = 1'b0;
        halted       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_inc;
                    tcnt_d  = 8'd0;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                tcnt_d  = 8'd0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_SUB: begin
                        alu_op = (op == OP_SUB) ? 2'b01 : 2'b00;
                        reg_we = 1'b1;
                    end
                    OP_ADDI: begin
                        alu_src_imm = 1'b1;
                        reg_we      = 1'b1;
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQZ: if (zero_flag) pc_d = pc_rel;
                    OP_JMP:  pc_d = pc_rel;
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op == OP_SW);
                if (mem_ack) begin
                    reg_we   = (op == OP_LW);
                    reg_wsel = (op == OP_LW);
                    tcnt_d   = 8'd0;
                    state_d  = S_FETCH;
                end else if (timed_out) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_HALT: halted = 1'b1;
            default: begin
                fault_d = 1'b1;
                state_d = S_HALT;
            end
        endcase

        // Keep the bus quiet while reset is held, even though state is already FETCH.
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            alu_op       = 2'b00;
            alu_src_imm  = 1'b0;
            reg_we       = 1'b0;
            reg_wsel     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 8'h00;
            fault_q <= 1'b0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign pc    = pc_q;
    assign ir    = ir_q;
    assign fault = fault_q;
    assign state = state_q;

endmodule

// File: tb/tb_cpu8_multicycle_ctrl.sv
// Directed bench for cpu8_multicycle_ctrl: vector table of single instructions
// plus hand-written LW/SW wait, timeout, HALT and mid-handshake reset sequences.
module tb_cpu8_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       zero_flag;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [1:0] alu_op;
    logic       alu_src_imm;
    logic       reg_we;
    logic       reg_wsel;
    logic       halted;
    logic       fault;
    logic [2:0] state;

    int n_total = 0;
    int n_pass  = 0;

    cpu8_multicycle_ctrl #(.PC_RESET(8'h00), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .zero_flag(zero_flag), .pc(pc), .ir(ir), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .reg_we(reg_we), .reg_wsel(reg_wsel),
        .halted(halted), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] instr;
        logic       zf;
        logic [7:0] pc_fetch;
        logic [7:0] pc_exec;
        logic       we;
        logic       imm;
        logic [1:0] aop;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ack = 1'b0; zero_flag = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    // Fetch one instruction with zero wait; leaves the DUT in DECODE.
    task automatic fetch(input logic [7:0] instr);
        chk("fetch_req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = instr;
        #1;
        step();
        mem_ack = 1'b0; mem_rdata = 8'hA5;
        #1;
    endtask

    initial begin
        vecs[0]  = '{8'h4F, 1'b0, 8'h01, 8'h01, 1'b1, 1'b1, 2'b00}; // ADDI r1,#-1
        vecs[1]  = '{8'h02, 1'b0, 8'h02, 8'h02, 1'b1, 1'b0, 2'b00}; // ADD
        vecs[2]  = '{8'hC4, 1'b0, 8'h03, 8'hFF, 1'b0, 1'b0, 2'b00}; // JMP -4
        vecs[3]  = '{8'hC6, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0, 2'b00}; // JMP -2
        vecs[4]  = '{8'hC3, 1'b0, 8'hFF, 8'h02, 1'b0, 1'b0, 2'b00}; // JMP +3 wraps
        vecs[5]  = '{8'h34, 1'b0, 8'h03, 8'h03, 1'b1, 1'b0, 2'b01}; // SUB
        vecs[6]  = '{8'hC3, 1'b0, 8'h04, 8'h07, 1'b0, 1'b0, 2'b00};
        vecs[7]  = '{8'hC3, 1'b0, 8'h08, 8'h0B, 1'b0, 1'b0, 2'b00};
        vecs[8]  = '{8'hC3, 1'b0, 8'h0C, 8'h0F, 1'b0, 1'b0, 2'b00};
        vecs[9]  = '{8'h02, 1'b0, 8'h10, 8'h10, 1'b1, 1'b0, 2'b00};
        vecs[10] = '{8'hA2, 1'b0, 8'h11, 8'h11, 1'b0, 1'b0, 2'b00}; // BEQZ +2 not taken
        vecs[11] = '{8'hC6, 1'b0, 8'h12, 8'h10, 1'b0, 1'b0, 2'b00};
        vecs[12] = '{8'hA2, 1'b1, 8'h11, 8'h13, 1'b0, 1'b0, 2'b00}; // BEQZ +2 taken
        vecs[13] = '{8'hAC, 1'b1, 8'h14, 8'h10, 1'b0, 1'b0, 2'b00}; // BEQZ -4 taken

        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00; zero_flag = 1'b0;
        step();
        step();
        chk("rst_state", state, 3'd0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_ir", ir, 8'h00);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_halted", halted, 1'b0);
        rst = 1'b0;
        #1;
        chk("first_fetch_req", mem_req, 1'b1);

        for (int i = 0; i < 14; i++) begin
            chk("v_fetch_state", state, 3'd0);
            chk("v_fetch_sel", mem_addr_sel, 1'b0);
            fetch(vecs[i].instr);
            chk("v_dec_state", state, 3'd1);
            chk("v_dec_ir", ir, vecs[i].instr);
            chk("v_dec_pc", pc, vecs[i].pc_fetch);
            chk("v_dec_strobes", {mem_req, reg_we}, 2'b00);
            step();
            zero_flag = vecs[i].zf;
            #1;
            chk("v_exec_state", state, 3'd2);
            chk("v_exec_we", reg_we, vecs[i].we);
            chk("v_exec_imm", alu_src_imm, vecs[i].imm);
            chk("v_exec_aop", alu_op, vecs[i].aop);
            chk("v_exec_wsel", reg_wsel, 1'b0);
            step();
            zero_flag = 1'b0;
            chk("v_next_state", state, 3'd0);
            chk("v_exec_pc", pc, vecs[i].pc_exec);
        end

        // LW r2,[r1] at 0x10 with two wait cycles
        fetch(8'h72);
        step();
        chk("lw_exec_strobes", {mem_req, reg_we}, 2'b00);
        step();
        for (int w = 0; w < 2; w++) begin
            chk("lw_wait_state", state, 3'd3);
            chk("lw_wait_bus", {mem_req, mem_addr_sel, mem_we}, 3'b110);
            chk("lw_wait_we", reg_we, 1'b0);
            step();
        end
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        #1;
        chk("lw_ack_bus", {mem_req, mem_addr_sel, mem_we}, 3'b110);
        chk("lw_ack_wb", {reg_we, reg_wsel}, 2'b11);
        step();
        mem_ack = 1'b0;
        #1;
        chk("lw_done_state", state, 3'd0);
        chk("lw_done_pc", pc, 8'h11);
        chk("lw_done_we", reg_we, 1'b0);

        // SW r2,[r1] at 0x11 with one wait cycle
        fetch(8'h92);
        step();
        step();
        chk("sw_wait_bus", {mem_req, mem_addr_sel, mem_we}, 3'b111);
        chk("sw_wait_we", reg_we, 1'b0);
        step();
        mem_ack = 1'b1;
        #1;
        chk("sw_ack_bus", {mem_req, mem_we}, 2'b11);
        chk("sw_ack_we", reg_we, 1'b0);
        step();
        mem_ack = 1'b0;
        #1;
        chk("sw_done_state", state, 3'd0);
        chk("sw_done_pc", pc, 8'h12);

        // Fetch timeout straight after reset
        do_reset();
        begin
            int reqs = 0;
            int i = 0;
            while (!halted && i < 12) begin
                if (mem_req) reqs++;
                step();
                i++;
            end
            chk("to_req_cycles", reqs, 4);
        end
        chk("to_halted", halted, 1'b1);
        chk("to_fault", fault, 1'b1);
        chk("to_state", state, 3'd4);
        chk("to_req_off", mem_req, 1'b0);
        step();
        step();
        chk("to_pc_frozen", pc, 8'h00);
        chk("to_still_halted", halted, 1'b1);
        do_reset();
        chk("to_rst_state", state, 3'd0);
        chk("to_rst_pc", pc, 8'h00);
        chk("to_rst_fault", fault, 1'b0);

        // HALT instruction is sticky; stray acks ignored
        fetch(8'hE0);
        step();
        step();
        chk("halt_state", state, 3'd4);
        chk("halt_fault", fault, 1'b0);
        mem_ack = 1'b1; mem_rdata = 8'h4F;
        #1;
        chk("halt_req", mem_req, 1'b0);
        step();
        mem_ack = 1'b0;
        step();
        chk("halt_sticky", halted, 1'b1);
        chk("halt_pc", pc, 8'h01);
        chk("halt_ir", ir, 8'hE0);

        // Reset in the middle of a MEM wait
        do_reset();
        fetch(8'h92);
        step();
        step();
        chk("mrst_wait_we", mem_we, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mrst_state", state, 3'd0);
        chk("mrst_pc", pc, 8'h00);
        chk("mrst_no_we", {mem_we, reg_we}, 2'b00);
        chk("mrst_req", mem_req, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu8_multicycle_ctrl.md
Name: cpu8_multicycle_ctrl

Overview:
Multi-cycle control unit for the 8-bit processor. It owns the PC and instruction register (IR), fetches instructions over a req/ack memory handshake and decodes the 3-bit opcode. It drives the per-cycle control strobes for the register file, ALU and memory. It also sign-extends the 3-bit immediate (instr[2:0]) internally for PC-relative branches and jumps; the datapath keeps its own extender for ALU immediates.

Parameters:
PC_RESET, 8'h00, PC value loaded on reset.
MEM_TIMEOUT, 15, max cycles to wait for mem_ack before faulting; range 1-255.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
mem_ack  in  1  memory completes the current request this cycle
mem_rdata  in  8  memory read data, valid when mem_ack=1
zero_flag  in  1  1 when register rd (instr[4:3]) reads zero
pc  out  8  program counter
ir  out  8  instruction register
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  write qualifier for mem_req (SW only)
mem_addr_sel  out  1  0 = address is pc, 1 = address is reg[rs]
alu_op  out  2  00 add, 01 sub, 10 pass-b, 11 unused
alu_src_imm  out  1  ALU operand B: 0 = reg[rs], 1 = datapath sign-extended imm
reg_we  out  1  register file write strobe, one-cycle pulse
reg_wsel  out  1  write-back source: 0 = ALU, 1 = mem_rdata
halted  out  1  in HALT state
fault  out  1  halted because of a memory timeout
state  out  3  current FSM state, for debug

Behaviour:
- Instruction fields: op = ir[7:5], rd = ir[4:3], rs = ir[2:1], imm3 = ir[2:0]. sext8 = {5{imm3[2]}, imm3}.
- Opcodes:
  - 000 ADD, 001 SUB, 010 ADDI, 011 LW rd,[rs], 100 SW rd,[rs]
  - 101 BEQZ rd,imm: pc = pc + sext8 if rd == 0
  - 110 JMP imm: pc = pc + sext8
  - 111 HALT
- PC arithmetic is modulo 256 and relative to the already-incremented PC (address of instr + 1).
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4. Codes 5-7 go to HALT with fault=1.
- Reset (any state, including mid-handshake): state=FETCH, pc=PC_RESET, ir=0, fault=0, timeout counter=0. All strobes are 0 in the cycle after reset; mem_req goes high in the first FETCH cycle.
- Strobes are combinational from state and ir and default to 0.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ack: ir <= mem_rdata, pc <= pc+1, go to DECODE.
  - Otherwise increment the timeout counter. If the counter reaches MEM_TIMEOUT without an ack: go to HALT with fault=1.
- DECODE: one cycle, no strobes. Clears the timeout counter. Go to EXEC.
- EXEC:
  - ADD/SUB: alu_op=00/01, alu_src_imm=0, reg_we=1, reg_wsel=0. Go to FETCH.
  - ADDI: alu_op=00, alu_src_imm=1, reg_we=1. Go to FETCH.
  - LW/SW: go to MEM, no strobes.
  - BEQZ: if zero_flag=1, pc <= pc + sext8. Go to FETCH.
  - JMP: pc <= pc + sext8. Go to FETCH.
  - HALT: go to HALT.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we = (op==SW).
  - On mem_ack: for LW, reg_we=1 and reg_wsel=1 in that same cycle. Go to FETCH.
  - Timeout behaves as in FETCH.
- HALT: sticky until rst. halted=1, all strobes 0, pc and ir frozen.
- A mem_ack while mem_req=0 is ignored.
- Cycles per instruction with zero-wait memory (ack in the first req cycle):
  - ALU, branch, JMP: 3
  - LW/SW: 4
  - Each wait cycle adds 1.

Test Plan:
- Reset then ADDI r1,#-1 (8'b010_01_111), ack immediate → pc 00→01; reg_we pulse in cycle 3 with alu_src_imm=1, alu_op=00; back in FETCH at cycle 4.
- JMP -4 at addr 0x02 (8'b110_00_100) → pc 0x03 after fetch, 0xFF after EXEC. JMP +3 at 0xFE → pc wraps to 0x02.
- BEQZ +2 at 0x10 with zero_flag=0 → pc=0x11. Same with zero_flag=1 → pc=0x13.
- LW r2,[r1] with 2 wait cycles in MEM → mem_req=1, mem_addr_sel=1, mem_we=0 for 3 cycles. reg_we=1 and reg_wsel=1 only in the ack cycle. SW → mem_we=1 and reg_we never asserted.
- MEM_TIMEOUT=4 with mem_ack held low in FETCH → mem_req high 4 cycles, then halted=1, fault=1, mem_req=0, pc frozen. Assert rst → FETCH, pc=PC_RESET, fault=0.
- HALT instruction, then pulse mem_ack → no state change and halted stays 1. rst asserted during a MEM wait → next cycle in FETCH with no reg_we and no stale mem_we.
